// File: rtl/fetch_queue_riscv.sv
// rtl/fetch_queue_riscv.sv - decoupled RISC-V fetch engine with DEPTH-entry instruction queue
// Requests are credit-limited so queue entries plus in-flight fetches never exceed DEPTH.
module fetch_queue_riscv #(
  parameter int unsigned     XLEN     = 64,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     CW       = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_en,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_instr,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [XLEN-1:0] dec_pc,
  output logic [31:0]     dec_instr,
  output logic            misalign_err,
  output logic [CW-1:0]   occupancy
);

  localparam int unsigned     PW       = $clog2(DEPTH);
  localparam logic [PW-1:0]   PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW:0]     DEPTH_C  = (CW + 1)'(DEPTH);
  localparam logic [XLEN-1:0] PC_STEP  = {{(XLEN-3){1'b0}}, 3'b100};

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic            misalign_q, misalign_d;

  logic [XLEN-1:0] pc_mem_q    [DEPTH];
  logic [31:0]     instr_mem_q [DEPTH];

  logic [CW:0]     credit_used;
  logic            req_fire, rsp_drop, push, pop;
  logic [CW-1:0]   req_inc, rsp_dec;
  logic [XLEN-1:0] redirect_base;

  assign credit_used    = {1'b0, count_q} + {1'b0, outst_q};
  assign imem_req_valid = rst_n && !redirect_en && (credit_used < DEPTH_C);
  assign imem_req_addr  = fetch_pc_q;

  assign dec_valid    = (count_q != '0);
  assign dec_pc       = pc_mem_q[head_q];
  assign dec_instr    = instr_mem_q[head_q];
  assign misalign_err = misalign_q;
  assign occupancy    = count_q;

  assign req_fire      = imem_req_valid && imem_req_ready;
  assign rsp_drop      = (drop_q != '0);
  assign push          = imem_rsp_valid && !rsp_drop && !redirect_en;
  assign pop           = dec_valid && dec_ready;
  assign req_inc       = {{(CW-1){1'b0}}, req_fire};
  assign rsp_dec       = {{(CW-1){1'b0}}, imem_rsp_valid};
  assign redirect_base = {redirect_pc[XLEN-1:2], 2'b00};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    misalign_d = redirect_en && (redirect_pc[1:0] != 2'b00);

    if (redirect_en) begin
      // Every request still in flight, minus one answered right now, returns stale data.
      fetch_pc_d = redirect_base;
      rsp_pc_d   = redirect_base;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      outst_d    = outst_q - rsp_dec;
      drop_d     = outst_q - rsp_dec;
    end else begin
      outst_d = outst_q + req_inc - rsp_dec;
      if (req_fire) fetch_pc_d = fetch_pc_q + PC_STEP;
      if (imem_rsp_valid && rsp_drop) drop_d = drop_q - CNT_ONE;
      if (push) begin
        tail_d   = tail_q + PTR_ONE;
        rsp_pc_d = rsp_pc_q + PC_STEP;
      end
      if (pop) head_d = head_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
      misalign_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      misalign_q <= misalign_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      pc_mem_q[tail_q]    <= rsp_pc_q;
      instr_mem_q[tail_q] <= imem_rsp_instr;
    end
  end

endmodule

// File: tb/tb_fetch_queue_riscv.sv
// tb/tb_fetch_queue_riscv.sv - self-checking bench for fetch_queue_riscv
// Memory and decode queue are modelled as plain queues tagged with a redirect epoch.
module tb_fetch_queue_riscv;
  localparam int          XLEN     = 64;
  localparam int          DEPTH    = 4;
  localparam int          CW       = 3;
  localparam logic [63:0] RESET_PC = 64'h0;

  logic            clk = 1'b0;
  logic            rst_n, redirect_en, imem_req_valid, imem_req_ready;
  logic [XLEN-1:0] redirect_pc, imem_req_addr, dec_pc;
  logic            imem_rsp_valid, dec_valid, dec_ready, misalign_err;
  logic [31:0]     imem_rsp_instr, dec_instr;
  logic [CW-1:0]   occupancy;

  fetch_queue_riscv #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_instr(imem_rsp_instr),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_pc(dec_pc), .dec_instr(dec_instr),
    .misalign_err(misalign_err), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] addr; int due; int epoch; } req_t;
  typedef struct { logic [63:0] pc; logic [31:0] instr; } ent_t;
  typedef struct { logic [63:0] target; logic [63:0] first_pc; logic mis; int lat; } rd_vec_t;

  req_t pend[$];
  ent_t mq[$];
  logic [63:0] m_fetch;
  logic        m_mis;
  int          epoch, cyc, lat, n_hs;
  bit          lat_rand;
  int          checks = 0, errors = 0;

  logic        rst_s, redir_s, dec_ready_s, req_ready_s;
  logic [63:0] redir_pc_s;
  logic        s_dec_valid, s_mis, s_rqv;
  logic [63:0] s_dec_pc, s_addr;
  logic [CW-1:0] s_occ;

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return a[33:2] * 32'h9E3779B1 + 32'h00000013;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    logic rv, exp_rqv, fire, pop;
    req_t r;
    ent_t e;
    rv = rst_s && (pend.size() > 0) && (pend[0].due <= cyc);
    rst_n          = rst_s;
    redirect_en    = redir_s;
    redirect_pc    = redir_pc_s;
    dec_ready      = dec_ready_s;
    imem_req_ready = req_ready_s;
    imem_rsp_valid = rv;
    imem_rsp_instr = rv ? instr_of(pend[0].addr) : 32'($urandom);
    exp_rqv = rst_s && !redir_s && ((mq.size() + pend.size()) < DEPTH);
    #3;
    chk("req_valid", imem_req_valid, exp_rqv);
    if (rst_s) begin
      chk("req_addr", imem_req_addr, m_fetch);
      chk("dec_valid", dec_valid, mq.size() != 0);
      chk("occupancy", occupancy, mq.size());
      chk("misalign_err", misalign_err, m_mis);
      if (mq.size() != 0) begin
        chk("dec_pc", dec_pc, mq[0].pc);
        chk("dec_instr", dec_instr, mq[0].instr);
      end
    end
    s_dec_valid = dec_valid; s_dec_pc = dec_pc; s_mis = misalign_err;
    s_occ = occupancy; s_rqv = imem_req_valid; s_addr = imem_req_addr;
    if (rst_s && dec_valid && dec_ready_s) n_hs++;

    fire = exp_rqv && req_ready_s;
    pop  = (mq.size() != 0) && dec_ready_s;
    if (!rst_s) begin
      mq.delete(); pend.delete();
      m_fetch = RESET_PC; m_mis = 1'b0; epoch++;
    end else if (redir_s) begin
      mq.delete(); epoch++;
      m_fetch = {redir_pc_s[63:2], 2'b00};
      m_mis   = (redir_pc_s[1:0] != 2'b00);
      if (rv) void'(pend.pop_front());
    end else begin
      m_mis = 1'b0;
      if (pop) void'(mq.pop_front());
      if (rv) begin
        r = pend.pop_front();
        if (r.epoch == epoch) begin
          e.pc = r.addr; e.instr = instr_of(r.addr);
          mq.push_back(e);
        end
      end
      if (fire) begin
        r.addr  = m_fetch;
        r.due   = cyc + (lat_rand ? int'($urandom_range(1, 4)) : lat);
        r.epoch = epoch;
        pend.push_back(r);
        m_fetch = m_fetch + 64'd4;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  rd_vec_t vecs[5];

  initial begin
    int p0;
    vecs[0] = '{64'h40, 64'h40, 1'b0, 3};
    vecs[1] = '{64'h42, 64'h40, 1'b1, 3};
    vecs[2] = '{64'h1003, 64'h1000, 1'b1, 1};
    vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 2};
    vecs[4] = '{64'h8000_0000_0000_0104, 64'h8000_0000_0000_0104, 1'b0, 1};

    rst_s = 1'b0; redir_s = 1'b0; redir_pc_s = '0; dec_ready_s = 1'b1; req_ready_s = 1'b1;
    lat = 1; lat_rand = 1'b0; cyc = 0; epoch = 0; n_hs = 0;
    m_fetch = RESET_PC; m_mis = 1'b0;
    repeat (2) step();
    rst_s = 1'b1;

    // first request right after release, first dec_valid two cycles later
    step(); chk("reset_req_addr", s_addr, RESET_PC); chk("lat_c0_valid", s_dec_valid, 0);
    step(); chk("lat_c1_valid", s_dec_valid, 0);
    step(); chk("lat_c2_valid", s_dec_valid, 1); chk("lat_c2_pc", s_dec_pc, RESET_PC);

    repeat (5) step();
    p0 = n_hs;
    repeat (20) step();
    chk("throughput", n_hs - p0, 20);

    dec_ready_s = 1'b0;
    repeat (10) step();
    chk("stall_occ", s_occ, DEPTH);
    chk("stall_req_valid", s_rqv, 0);
    dec_ready_s = 1'b1;
    repeat (8) step();

    for (int i = 0; i < 5; i++) begin
      lat = vecs[i].lat;
      repeat (8) step();
      redir_s = 1'b1; redir_pc_s = vecs[i].target;
      step();
      redir_s = 1'b0;
      step();
      chk("redir_mis_pulse", s_mis, vecs[i].mis);
      chk("redir_dec_valid_r1", s_dec_valid, 0);
      step();
      chk("redir_mis_end", s_mis, 0);
      for (int k = 0; k < 30 && !s_dec_valid; k++) step();
      chk("redir_first_valid", s_dec_valid, 1);
      chk("redir_first_pc", s_dec_pc, vecs[i].first_pc);
    end

    // back-to-back redirects: last one wins
    lat = 2;
    repeat (6) step();
    redir_s = 1'b1; redir_pc_s = 64'h200; step();
    redir_pc_s = 64'h300; step();
    redir_s = 1'b0;
    for (int k = 0; k < 30 && !s_dec_valid; k++) step();
    chk("b2b_first_pc", s_dec_pc, 64'h300);

    // reset with a loaded queue and fetches in flight
    lat = 3; dec_ready_s = 1'b0;
    repeat (6) step();
    rst_s = 1'b0; step();
    rst_s = 1'b1; step();
    chk("rst_dec_valid", s_dec_valid, 0);
    chk("rst_occ", s_occ, 0);
    chk("rst_req_valid", s_rqv, 1);
    chk("rst_req_addr", s_addr, RESET_PC);
    dec_ready_s = 1'b1;
    repeat (10) step();

    lat_rand = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      dec_ready_s = ($urandom_range(0, 3) != 0);
      req_ready_s = ($urandom_range(0, 9) < 7);
      redir_s     = ($urandom_range(0, 99) < 3);
      redir_pc_s  = {32'($urandom), 32'($urandom)};
      rst_s       = ($urandom_range(0, 999) >= 3);
      step();
    end
    rst_s = 1'b1; redir_s = 1'b0; dec_ready_s = 1'b1; req_ready_s = 1'b1;
    repeat (20) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_queue_riscv.md
# fetch_queue_riscv

Parametrised, decoupled RISC-V instruction fetch stage. It replaces the fixed one-instruction-per-cycle PC register with a fetch engine that talks to a variable-latency instruction memory over a valid/ready request and in-order response channel. Fetched instructions land in a DEPTH-entry queue, which decode drains with valid/ready. Branch redirects flush the queue and discard in-flight responses.

## Interface
- XLEN, 64, PC/address width
- DEPTH, 4, queue entries; power of two, ≥2; also the maximum number of entries plus outstanding requests
- RESET_PC, 0, fetch address after reset
- CW = clog2(DEPTH+1), derived counter width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous and active-low
- redirect_en  in  1  branch/jump redirect strobe
- redirect_pc  in  XLEN  redirect target
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  fetch address
- imem_rsp_valid  in  1  response valid; responses return in request order, one per accepted request, no backpressure
- imem_rsp_instr  in  32  fetched instruction
- dec_valid  out  1  queue head valid
- dec_ready  in  1  decode accepts head
- dec_pc  out  XLEN  PC of head instruction
- dec_instr  out  32  head instruction
- misalign_err  out  1  one-cycle pulse: redirect_pc[1:0] != 0
- occupancy  out  CW  valid queue entries

## Operation
- State:
  - fetch_pc: next request address
  - rsp_pc: PC of the next expected response
  - queue: circular, with head/tail pointers and count
  - outstanding: accepted requests not yet answered
  - drop_cnt: responses still to discard
- Request: imem_req_valid = !redirect_en && (count + outstanding < DEPTH). imem_req_addr = fetch_pc.
  - On a request handshake: fetch_pc += 4 and outstanding += 1.
  - The credit rule guarantees the queue never overflows.
- Response: every imem_rsp_valid decrements outstanding.
  - If drop_cnt > 0: discard the response and decrement drop_cnt.
  - Otherwise: push {rsp_pc, imem_rsp_instr} at the tail and rsp_pc += 4.
- Dequeue: dec_valid = (count != 0). dec_pc/dec_instr show the head entry. On dec_valid && dec_ready the head advances.
- Push and pop in the same cycle leave count unchanged. A full queue with a simultaneous pop and push is legal.
- Redirect (redirect_en=1), which has priority over all else:
  - fetch_pc ← {redirect_pc[XLEN-1:2], 2'b00}; rsp_pc ← same.
  - count, head and tail are cleared. A pop in the same cycle counts as accepted but is irrelevant.
  - drop_cnt ← outstanding − imem_rsp_valid. A response arriving in the redirect cycle is itself discarded.
  - No request is issued that cycle.
  - misalign_err pulses next cycle if redirect_pc[1:0] != 0.
- Back-to-back redirects: the last one wins, and drop_cnt is recomputed each time.
- Arithmetic: PCs wrap modulo 2^XLEN. Pointers wrap modulo DEPTH.

## Timing
- Reset (rst_n=0 at a clk edge):
  - fetch_pc = rsp_pc = RESET_PC.
  - count = outstanding = drop_cnt = 0.
  - dec_valid = 0, occupancy = 0, misalign_err = 0.
  - imem_req_valid = 0 while rst_n is low.
- Reset mid-operation discards all queue contents and in-flight tracking. The memory is assumed to be reset by the same rst_n.
- First request is presented in the first cycle after rst_n goes high.
- Latency: request accepted in cycle N, response in cycle M ≥ N+1, dec_valid in cycle M+1.
  - With zero-wait memory (response at N+1) and dec_ready held at 1, throughput is one instruction per cycle.
- Redirect in cycle R: first new request at R+1; dec_valid is 0 at R+1.
- All outputs except imem_req_valid, imem_req_addr, dec_valid, dec_pc and dec_instr are registered. Those five are driven from registered state, plus redirect_en for imem_req_valid.

## Test plan
- Reset then stream (DEPTH=4, RESET_PC=0, 1-cycle memory, dec_ready=1) → dec_pc = 0,4,8,… on consecutive cycles; dec_instr matches memory contents.
- dec_ready=0 for 10 cycles → occupancy saturates at 4, imem_req_valid=0, no lost or duplicate entries. Then dec_ready=1 → PCs resume with no gap.
- 3-cycle memory latency with 3 requests outstanding, redirect to 0x40 → the 3 stale responses are dropped and the first dec_pc is 0x40.
- Redirect in the same cycle as imem_rsp_valid → that response is discarded and drop_cnt = outstanding−1.
- Redirect to 0x42 → fetch resumes at 0x40 and misalign_err pulses for exactly one cycle.
- rst_n low while the queue is full and requests are in flight → next cycle dec_valid=0, occupancy=0; after release the first request addr is RESET_PC.
